// File: rtl/wb_retire_stage_pkg.sv
// Shared layout of the MS->WS bus and the retire-stage action encoding.
// The bus is {gr_we, dest, result, pc}, MSB first, with pc in the low bits.
package wb_retire_stage_pkg;

    typedef enum logic [1:0] {
        WS_HOLD,
        WS_RETIRE,
        WS_FLUSH,
        WS_RESET
    } ws_action_e;

    function automatic int ws_bus_wd(input int rf_aw, input int data_w, input int pc_w);
        return 1 + rf_aw + data_w + pc_w;
    endfunction

    function automatic int ws_pc_lsb();
        return 0;
    endfunction

    function automatic int ws_result_lsb(input int pc_w);
        return pc_w;
    endfunction

    function automatic int ws_dest_lsb(input int data_w, input int pc_w);
        return pc_w + data_w;
    endfunction

    function automatic int ws_gr_we_pos(input int rf_aw, input int data_w, input int pc_w);
        return pc_w + data_w + rf_aw;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Generic synchronous FIFO used as the retire buffer; head entry is read combinationally.
// Pointers wrap naturally because DEPTH is a power of two.
module wb_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign push_ok = push_i && (count_q != CNT_W'(DEPTH));
    assign pop_ok  = pop_i  && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/wb_retire_stage.sv
// Write-back retire stage: buffers MS results, retires them in order to the RF,
// and publishes a pending-write scoreboard for the decode-stage hazard check.
module wb_retire_stage
    import wb_retire_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned RF_AW  = 5,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            ms_to_ws_valid,
    input  logic [1+RF_AW+DATA_W+PC_W-1:0]  ms_to_ws_bus,
    output logic                            ws_allowin,
    input  logic                            retire_stall,
    input  logic                            ws_flush,
    output logic                            ws_rf_we,
    output logic [RF_AW-1:0]                ws_rf_waddr,
    output logic [DATA_W-1:0]               ws_rf_wdata,
    output logic [2**RF_AW-1:0]             ws_busy_mask,
    output logic                            ws_to_ds_valid,
    output logic [$clog2(DEPTH):0]          ws_count,
    output logic [PC_W-1:0]                 debug_wb_pc,
    output logic [DATA_W/8-1:0]             debug_wb_rf_we,
    output logic [RF_AW-1:0]                debug_wb_rf_wnum,
    output logic [DATA_W-1:0]               debug_wb_rf_wdata
);

    localparam int BUS_W      = ws_bus_wd(RF_AW, DATA_W, PC_W);
    localparam int PC_LSB     = ws_pc_lsb();
    localparam int RESULT_LSB = ws_result_lsb(PC_W);
    localparam int DEST_LSB   = ws_dest_lsb(DATA_W, PC_W);
    localparam int GR_WE_POS  = ws_gr_we_pos(RF_AW, DATA_W, PC_W);
    localparam int CNT_W      = $clog2(DEPTH) + 1;
    localparam int NREG       = 2**RF_AW;

    logic [BUS_W-1:0]  head_bus;
    logic [CNT_W-1:0]  count;
    logic              push, pop, nonempty;
    logic              in_we, head_we;
    logic [RF_AW-1:0]  in_dest, head_dest;
    logic [DATA_W-1:0] head_result;
    logic [PC_W-1:0]   head_pc;
    ws_action_e        action;

    logic [CNT_W-1:0]  pend_q [NREG];
    logic [CNT_W-1:0]  pend_d [NREG];

    assign in_we       = ms_to_ws_bus[GR_WE_POS];
    assign in_dest     = ms_to_ws_bus[DEST_LSB +: RF_AW];
    assign head_we     = head_bus[GR_WE_POS];
    assign head_dest   = head_bus[DEST_LSB +: RF_AW];
    assign head_result = head_bus[RESULT_LSB +: DATA_W];
    assign head_pc     = head_bus[PC_LSB +: PC_W];

    assign nonempty   = (count != '0);
    assign ws_allowin = (count < CNT_W'(DEPTH));
    assign push       = ms_to_ws_valid && ws_allowin && !ws_flush;

    // Reset and flush both suppress retirement so nothing reaches the RF in those cycles.
    always_comb begin
        action = WS_HOLD;
        if (!resetn) begin
            action = WS_RESET;
        end else if (ws_flush) begin
            action = WS_FLUSH;
        end else if (nonempty && !retire_stall) begin
            action = WS_RETIRE;
        end
    end

    assign pop = (action == WS_RETIRE);

    wb_fifo #(
        .WIDTH (BUS_W),
        .DEPTH (DEPTH)
    ) u_wb_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .flush_i (ws_flush),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (ms_to_ws_bus),
        .rdata_o (head_bus),
        .count_o (count)
    );

    // Per-register pending-write counters; a register stays busy while any buffered entry targets it.
    always_comb begin
        pend_d = pend_q;
        if (action == WS_FLUSH || action == WS_RESET) begin
            for (int r = 0; r < NREG; r++) begin
                pend_d[r] = '0;
            end
        end else begin
            if (push && in_we && (in_dest != '0)) begin
                pend_d[in_dest] = pend_d[in_dest] + CNT_W'(1);
            end
            if (pop && head_we && (head_dest != '0)) begin
                pend_d[head_dest] = pend_d[head_dest] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int r = 0; r < NREG; r++) begin
                pend_q[r] <= '0;
            end
        end else begin
            pend_q <= pend_d;
        end
    end

    always_comb begin
        ws_busy_mask = '0;
        for (int r = 1; r < NREG; r++) begin
            ws_busy_mask[r] = (pend_q[r] != '0);
        end
    end

    assign ws_rf_we       = pop && head_we && (head_dest != '0);
    assign ws_rf_waddr    = nonempty ? head_dest   : '0;
    assign ws_rf_wdata    = nonempty ? head_result : '0;
    assign debug_wb_pc    = nonempty ? head_pc     : '0;
    assign ws_to_ds_valid = nonempty;
    assign ws_count       = count;

    assign debug_wb_rf_we    = {(DATA_W/8){ws_rf_we}};
    assign debug_wb_rf_wnum  = ws_rf_waddr;
    assign debug_wb_rf_wdata = ws_rf_wdata;

endmodule
